// File: rtl/game_pkg.sv
// Shared battleship types: board size, responder states and packed grid position.
package game_pkg;
  localparam int GRID_SIZE = 10;

  typedef enum logic [2:0] {
    PLACE,
    ARMED,
    LOOKUP,
    RESPOND,
    LOST
  } resp_state_t;

  typedef struct packed {
    logic [3:0] row;
    logic [3:0] col;
  } pos_t;
endpackage

// File: rtl/board_map.sv
// Ship and shot bitmaps: one synchronous set port per map, one shared combinational read.
module board_map #(
  parameter int CELLS = 100,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_ship_set,
  input  logic [AW-1:0] i_ship_addr,
  input  logic          i_shot_set,
  input  logic [AW-1:0] i_shot_addr,
  input  logic [AW-1:0] i_rd_addr,
  output logic          o_ship_bit,
  output logic          o_shot_bit
);
  localparam logic [AW-1:0] LAST = AW'(CELLS - 1);

  logic [CELLS-1:0] r_ship;
  logic [CELLS-1:0] r_shot;
  logic             w_rd_ok;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_ship <= '0;
      r_shot <= '0;
    end else begin
      if (i_ship_set && (i_ship_addr <= LAST)) r_ship[i_ship_addr] <= 1'b1;
      if (i_shot_set && (i_shot_addr <= LAST)) r_shot[i_shot_addr] <= 1'b1;
    end
  end

  // Addresses past the board read as empty rather than indexing off the vector.
  assign w_rd_ok    = (i_rd_addr <= LAST);
  assign o_ship_bit = w_rd_ok ? r_ship[i_rd_addr] : 1'b0;
  assign o_shot_bit = w_rd_ok ? r_shot[i_rd_addr] : 1'b0;
endmodule

// File: rtl/shot_responder.sv
// Defending-side responder: holds the local ship map and answers opponent shots over valid/ready.
module shot_responder
  import game_pkg::*;
#(
  parameter int GRID = GRID_SIZE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       place_en,
  input  logic [7:0] place_pos,
  input  logic       arm,
  input  logic       shot_valid,
  input  logic [7:0] shot_pos,
  output logic       shot_ready,
  output logic       ans_valid,
  input  logic       ans_ready,
  output logic       ans_hit,
  output logic       ans_repeat,
  output logic       ans_err,
  output logic [6:0] cells_placed,
  output logic [6:0] cells_hit,
  output logic       fleet_lost
);
  localparam int CELLS = GRID * GRID;

  function automatic logic in_range(input pos_t p);
    return (p.row < 4'(GRID)) && (p.col < 4'(GRID));
  endfunction

  function automatic logic [6:0] cell_addr(input pos_t p);
    return 7'(p.row) * 7'(GRID) + 7'(p.col);
  endfunction

  resp_state_t r_state;
  pos_t        r_shot;
  logic        r_shot_ready;
  logic        r_ans_valid;
  logic        r_ans_hit;
  logic        r_ans_repeat;
  logic        r_ans_err;
  logic        r_fleet_lost;
  logic [6:0]  r_placed;
  logic [6:0]  r_hits;

  pos_t       w_place;
  logic       w_place_ok;
  logic       w_shot_ok;
  logic [6:0] w_place_addr;
  logic [6:0] w_shot_addr;
  logic [6:0] w_rd_addr;
  logic       w_ship_bit;
  logic       w_shot_bit;
  logic       w_ship_set;
  logic       w_shot_set;
  logic [6:0] w_placed_next;

  assign w_place      = pos_t'(place_pos);
  assign w_place_ok   = in_range(w_place);
  assign w_shot_ok    = in_range(r_shot);
  assign w_place_addr = cell_addr(w_place);
  assign w_shot_addr  = cell_addr(r_shot);

  // Placement and lookup never overlap, so one read port serves both.
  assign w_rd_addr     = (r_state == PLACE) ? w_place_addr : w_shot_addr;
  assign w_ship_set    = !clear && (r_state == PLACE) && place_en && w_place_ok && !w_ship_bit;
  assign w_shot_set    = !clear && (r_state == LOOKUP) && w_shot_ok;
  assign w_placed_next = r_placed + 7'(w_ship_set);

  board_map #(
    .CELLS(CELLS),
    .AW   (7)
  ) u_map (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (clear),
    .i_ship_set (w_ship_set),
    .i_ship_addr(w_place_addr),
    .i_shot_set (w_shot_set),
    .i_shot_addr(w_shot_addr),
    .i_rd_addr  (w_rd_addr),
    .o_ship_bit (w_ship_bit),
    .o_shot_bit (w_shot_bit)
  );

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_state      <= PLACE;
      r_shot_ready <= 1'b0;
      r_ans_valid  <= 1'b0;
      r_ans_hit    <= 1'b0;
      r_ans_repeat <= 1'b0;
      r_ans_err    <= 1'b0;
      r_fleet_lost <= 1'b0;
      r_placed     <= '0;
      r_hits       <= '0;
    end else begin
      case (r_state)
        PLACE: begin
          // Arm sees the count including a placement made in the same cycle.
          r_placed <= w_placed_next;
          if (arm && (w_placed_next != 7'd0)) begin
            r_state      <= ARMED;
            r_shot_ready <= 1'b1;
          end
        end
        ARMED: begin
          if (shot_valid) begin
            r_shot       <= pos_t'(shot_pos);
            r_shot_ready <= 1'b0;
            r_state      <= LOOKUP;
          end
        end
        LOOKUP: begin
          r_ans_err    <= !w_shot_ok;
          r_ans_hit    <= w_shot_ok && w_ship_bit;
          r_ans_repeat <= w_shot_ok && w_shot_bit;
          if (w_shot_ok && w_ship_bit && !w_shot_bit) r_hits <= r_hits + 7'd1;
          r_ans_valid  <= 1'b1;
          r_state      <= RESPOND;
        end
        RESPOND: begin
          if (ans_ready) begin
            r_ans_valid <= 1'b0;
            if (r_hits == r_placed) begin
              r_state      <= LOST;
              r_fleet_lost <= 1'b1;
            end else begin
              r_state      <= ARMED;
              r_shot_ready <= 1'b1;
            end
          end
        end
        LOST: begin
          r_fleet_lost <= 1'b1;
        end
        default: begin
          r_state <= PLACE;
        end
      endcase
    end
  end

  assign shot_ready   = r_shot_ready;
  assign ans_valid    = r_ans_valid;
  assign ans_hit      = r_ans_hit;
  assign ans_repeat   = r_ans_repeat;
  assign ans_err      = r_ans_err;
  assign cells_placed = r_placed;
  assign cells_hit    = r_hits;
  assign fleet_lost   = r_fleet_lost;
endmodule

// File: tb/tb_shot_responder.sv
// Bench for shot_responder: directed game scenario plus randomized play against a board-level model.
module tb_shot_responder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       place_en = 1'b0;
  logic [7:0] place_pos = 8'h00;
  logic       arm = 1'b0;
  logic       shot_valid = 1'b0;
  logic [7:0] shot_pos = 8'h00;
  logic       shot_ready;
  logic       ans_valid;
  logic       ans_ready = 1'b0;
  logic       ans_hit;
  logic       ans_repeat;
  logic       ans_err;
  logic [6:0] cells_placed;
  logic [6:0] cells_hit;
  logic       fleet_lost;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  shot_responder #(.GRID(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .place_en    (place_en),
    .place_pos   (place_pos),
    .arm         (arm),
    .shot_valid  (shot_valid),
    .shot_pos    (shot_pos),
    .shot_ready  (shot_ready),
    .ans_valid   (ans_valid),
    .ans_ready   (ans_ready),
    .ans_hit     (ans_hit),
    .ans_repeat  (ans_repeat),
    .ans_err     (ans_err),
    .cells_placed(cells_placed),
    .cells_hit   (cells_hit),
    .fleet_lost  (fleet_lost)
  );

  always #5 clk = ~clk;

  // Game-level model: 2-D boards, counts, and which phase of the exchange we are in.
  localparam int M_PLACE = 0, M_WAIT = 1, M_JUDGE = 2, M_ANSWER = 3, M_LOST = 4;
  bit         m_ship[10][10];
  bit         m_shot[10][10];
  int         m_phase;
  int         m_placed;
  int         m_hits;
  bit         m_hit, m_rep, m_err;
  logic [7:0] m_pos;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++) begin
        m_ship[r][c] = 1'b0;
        m_shot[r][c] = 1'b0;
      end
    m_phase  = M_PLACE;
    m_placed = 0;
    m_hits   = 0;
  endtask

  task automatic model_step();
    int r, c;
    if (rst || clear) begin
      model_clear();
    end else begin
      case (m_phase)
        M_PLACE: begin
          r = int'(place_pos[7:4]);
          c = int'(place_pos[3:0]);
          if (place_en && r < 10 && c < 10 && !m_ship[r][c]) begin
            m_ship[r][c] = 1'b1;
            m_placed++;
          end
          if (arm && m_placed > 0) m_phase = M_WAIT;
        end
        M_WAIT: begin
          if (shot_valid) begin
            m_pos   = shot_pos;
            m_phase = M_JUDGE;
          end
        end
        M_JUDGE: begin
          r = int'(m_pos[7:4]);
          c = int'(m_pos[3:0]);
          if (r < 10 && c < 10) begin
            m_err = 1'b0;
            m_hit = m_ship[r][c];
            m_rep = m_shot[r][c];
            if (m_hit && !m_rep) m_hits++;
            m_shot[r][c] = 1'b1;
          end else begin
            m_err = 1'b1;
            m_hit = 1'b0;
            m_rep = 1'b0;
          end
          m_phase = M_ANSWER;
        end
        M_ANSWER: begin
          if (ans_ready) m_phase = (m_hits == m_placed) ? M_LOST : M_WAIT;
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("cmp_shot_ready", int'(shot_ready), int'(m_phase == M_WAIT));
        chk("cmp_ans_valid", int'(ans_valid), int'(m_phase == M_ANSWER));
        chk("cmp_fleet_lost", int'(fleet_lost), int'(m_phase == M_LOST));
        chk("cmp_cells_placed", int'(cells_placed), m_placed);
        chk("cmp_cells_hit", int'(cells_hit), m_hits);
        if (m_phase == M_ANSWER) begin
          chk("cmp_ans_hit", int'(ans_hit), int'(m_hit));
          chk("cmp_ans_repeat", int'(ans_repeat), int'(m_rep));
          chk("cmp_ans_err", int'(ans_err), int'(m_err));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic place(input logic [7:0] pos);
    place_en  = 1'b1;
    place_pos = pos;
    step();
    place_en  = 1'b0;
  endtask

  task automatic do_shot(input logic [7:0] pos, input int hold,
                         input int eh, input int er, input int ee);
    shot_valid = 1'b1;
    shot_pos   = pos;
    ans_ready  = (hold == 0);
    step();
    shot_valid = 1'b0;
    chk("lookup_no_valid", int'(ans_valid), 0);
    step();
    chk("ans_valid_rise", int'(ans_valid), 1);
    chk("lit_ans_hit", int'(ans_hit), eh);
    chk("lit_ans_repeat", int'(ans_repeat), er);
    chk("lit_ans_err", int'(ans_err), ee);
    for (int k = 0; k < hold; k++) begin
      step();
      chk("hold_valid", int'(ans_valid), 1);
      chk("hold_hit", int'(ans_hit), eh);
      chk("hold_err", int'(ans_err), ee);
      chk("hold_ready_low", int'(shot_ready), 0);
    end
    ans_ready = 1'b1;
    step();
    ans_ready = 1'b0;
  endtask

  initial begin
    step();
    step();
    chk("rst_shot_ready", int'(shot_ready), 0);
    chk("rst_ans_valid", int'(ans_valid), 0);
    chk("rst_ans_hit", int'(ans_hit), 0);
    chk("rst_ans_repeat", int'(ans_repeat), 0);
    chk("rst_ans_err", int'(ans_err), 0);
    chk("rst_fleet_lost", int'(fleet_lost), 0);
    chk("rst_cells_placed", int'(cells_placed), 0);
    chk("rst_cells_hit", int'(cells_hit), 0);
    rst    = 1'b0;
    chk_en = 1'b1;

    place(8'h00);
    place(8'h11);
    place(8'h11);
    place(8'hA0);
    chk("lit_placed_2", int'(cells_placed), 2);
    chk("lit_place_not_ready", int'(shot_ready), 0);
    arm = 1'b1;
    step();
    arm = 1'b0;
    chk("lit_armed_ready", int'(shot_ready), 1);

    do_shot(8'h11, 0, 1, 0, 0);
    chk("lit_hits_1", int'(cells_hit), 1);
    do_shot(8'h11, 0, 1, 1, 0);
    chk("lit_hits_still_1", int'(cells_hit), 1);
    do_shot(8'h55, 0, 0, 0, 0);
    do_shot(8'h0C, 5, 0, 0, 1);
    chk("lit_err_no_hit_change", int'(cells_hit), 1);
    do_shot(8'h00, 0, 1, 0, 0);
    chk("lit_fleet_lost", int'(fleet_lost), 1);
    chk("lit_hits_2", int'(cells_hit), 2);
    shot_valid = 1'b1;
    shot_pos   = 8'h22;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("lit_lost_no_accept", int'(shot_ready), 0);
      chk("lit_lost_held", int'(fleet_lost), 1);
    end
    shot_valid = 1'b0;

    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("lit_clear_lost", int'(fleet_lost), 0);
    place(8'h33);
    arm = 1'b1;
    step();
    arm = 1'b0;
    shot_valid = 1'b1;
    shot_pos   = 8'h33;
    step();
    shot_valid = 1'b0;
    step();
    chk("lit_pre_clear_valid", int'(ans_valid), 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("lit_clear_valid", int'(ans_valid), 0);
    chk("lit_clear_placed", int'(cells_placed), 0);
    chk("lit_clear_hits", int'(cells_hit), 0);
    chk("lit_clear_ready", int'(shot_ready), 0);
    arm = 1'b1;
    step();
    arm = 1'b0;
    chk("lit_arm_empty", int'(shot_ready), 0);
    place_en  = 1'b1;
    place_pos = 8'h22;
    arm       = 1'b1;
    step();
    place_en  = 1'b0;
    arm       = 1'b0;
    chk("lit_place_arm_same", int'(shot_ready), 1);
    chk("lit_place_arm_count", int'(cells_placed), 1);

    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom_range(0, 599) == 0);
      clear      = ($urandom_range(0, 299) == 0);
      place_en   = ($urandom_range(0, 1) == 1);
      place_pos  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                 : {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      arm        = ($urandom_range(0, 5) == 0);
      shot_valid = ($urandom_range(0, 1) == 1);
      shot_pos   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                 : {4'($urandom_range(0, 4)), 4'($urandom_range(0, 4))};
      ans_ready  = ($urandom_range(0, 2) != 0);
      if (fleet_lost && $urandom_range(0, 9) == 0) clear = 1'b1;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
